// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operand handshake in, registered result and flags out.
interface alu_seq_if #(
  parameter int BUS = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [BUS-1:0] a;
  logic [BUS-1:0] b;
  logic           carry_in;
  logic [3:0]     op_code;
  logic           out_valid;
  logic           out_ready;
  logic [BUS-1:0] y;
  logic [BUS-1:0] y_hi;
  logic           carry_out;
  logic           borrow;
  logic           zero;
  logic           parity;
  logic           invalid_op;
  logic           busy;

  modport master (
    output in_valid, a, b, carry_in, op_code, out_ready,
    input  in_ready, out_valid, y, y_hi, carry_out, borrow, zero, parity, invalid_op, busy
  );

  modport slave (
    input  in_valid, a, b, carry_in, op_code, out_ready,
    output in_ready, out_valid, y, y_hi, carry_out, borrow, zero, parity, invalid_op, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus a BUS-cycle shift-add multiplier,
// with a one-entry result register under valid/ready flow control.
module alu_seq #(
  parameter int BUS = 8
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd1,
    OP_ADC = 4'd2,
    OP_SUB = 4'd3,
    OP_INC = 4'd4,
    OP_DEC = 4'd5,
    OP_AND = 4'd6,
    OP_NOT = 4'd7,
    OP_ROL = 4'd8,
    OP_ROR = 4'd9,
    OP_OR  = 4'd10,
    OP_XOR = 4'd11,
    OP_MUL = 4'd12
  } op_t;

  localparam int CW = $clog2(BUS);

  state_t state, state_nx;

  logic           accept;
  logic           is_mul;
  logic           last_step;

  logic [BUS-1:0] mcand;
  logic [BUS-1:0] acc_hi;
  logic [BUS-1:0] acc_lo;
  logic [CW-1:0]  cnt;

  logic [BUS:0]   step_sum;
  logic [BUS-1:0] step_hi;
  logic [BUS-1:0] step_lo;

  logic [BUS:0]   sum;
  logic [BUS-1:0] alu_y;
  logic           alu_c;
  logic           alu_bw;
  logic           alu_inv;
  logic           alu_z;
  logic           alu_p;

  logic [BUS-1:0] y_r;
  logic [BUS-1:0] y_hi_r;
  logic           carry_r;
  logic           borrow_r;
  logic           zero_r;
  logic           parity_r;
  logic           inv_r;

  assign bus.in_ready  = rst_n && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign is_mul        = (bus.op_code == OP_MUL);
  assign last_step     = (state == MUL) && (cnt == CW'(BUS - 1));

  assign bus.out_valid  = (state == HOLD);
  assign bus.busy       = (state == MUL);
  assign bus.y          = y_r;
  assign bus.y_hi       = y_hi_r;
  assign bus.carry_out  = carry_r;
  assign bus.borrow     = borrow_r;
  assign bus.zero       = zero_r;
  assign bus.parity     = parity_r;
  assign bus.invalid_op = inv_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = is_mul ? MUL : HOLD;
      MUL:  if (last_step) state_nx = HOLD;
      HOLD: begin
        // accept in HOLD implies out_ready, so the result is consumed in the same cycle
        if (accept)             state_nx = is_mul ? MUL : HOLD;
        else if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sum     = '0;
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_bw  = 1'b0;
    alu_inv = 1'b0;
    case (bus.op_code)
      OP_ADD: begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b};
        alu_y = sum[BUS-1:0];
        alu_c = sum[BUS];
      end
      OP_ADC: begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{BUS{1'b0}}, bus.carry_in};
        alu_y = sum[BUS-1:0];
        alu_c = sum[BUS];
      end
      OP_SUB: begin
        alu_y  = bus.a - bus.b;
        alu_bw = (bus.a < bus.b);
      end
      OP_INC: begin
        sum   = {1'b0, bus.a} + {{BUS{1'b0}}, 1'b1};
        alu_y = sum[BUS-1:0];
        alu_c = sum[BUS];
      end
      OP_DEC: begin
        alu_y  = bus.a - {{(BUS-1){1'b0}}, 1'b1};
        alu_bw = (bus.a == '0);
      end
      OP_AND: alu_y = bus.a & bus.b;
      OP_NOT: alu_y = ~bus.a;
      OP_ROL: begin
        alu_y = {bus.a[BUS-2:0], bus.a[BUS-1]};
        alu_c = bus.a[BUS-1];
      end
      OP_ROR: begin
        alu_y = {bus.a[0], bus.a[BUS-1:1]};
        alu_c = bus.a[0];
      end
      OP_OR:  alu_y = bus.a | bus.b;
      OP_XOR: alu_y = bus.a ^ bus.b;
      OP_MUL: alu_y = '0;
      default: alu_inv = 1'b1;
    endcase
    alu_z = (alu_y == '0) && !alu_inv;
    alu_p = ^alu_y;
  end

  // One multiplier bit per cycle: conditionally add the multiplicand into the upper half,
  // then shift {carry, upper, lower} right so the product accumulates across both halves.
  always_comb begin
    step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    step_hi  = step_sum[BUS:1];
    step_lo  = {step_sum[0], acc_lo[BUS-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      y_r      <= '0;
      y_hi_r   <= '0;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      zero_r   <= 1'b0;
      parity_r <= 1'b0;
      inv_r    <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= bus.a;
        acc_hi <= '0;
        acc_lo <= bus.b;
        cnt    <= '0;
      end else begin
        y_r      <= alu_y;
        y_hi_r   <= '0;
        carry_r  <= alu_c;
        borrow_r <= alu_bw;
        zero_r   <= alu_z;
        parity_r <= alu_p;
        inv_r    <= alu_inv;
      end
    end else if (state == MUL) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + CW'(1);
      if (last_step) begin
        y_r      <= step_lo;
        y_hi_r   <= step_hi;
        carry_r  <= (step_hi != '0);
        borrow_r <= 1'b0;
        zero_r   <= ({step_hi, step_lo} == '0);
        parity_r <= ^{step_hi, step_lo};
        inv_r    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at BUS=8 and BUS=16 against an arithmetic reference model.
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  alu_seq_if #(.BUS(8))  if8 ();
  alu_seq_if #(.BUS(16)) if16 ();

  alu_seq #(.BUS(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  alu_seq #(.BUS(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    longint y;
    longint hi;
    bit     c;
    bit     bw;
    bit     z;
    bit     p;
    bit     inv;
  } res_t;

  function automatic res_t model(int w, int op, longint a, longint b, int cin);
    res_t   r;
    longint m = longint'(1) << w;
    longint v;
    int     ones;
    r.y = 0; r.hi = 0; r.c = 0; r.bw = 0; r.inv = 0;
    case (op)
      1:  begin v = a + b;       r.y = v % m; r.c = (v >= m); end
      2:  begin v = a + b + cin; r.y = v % m; r.c = (v >= m); end
      3:  begin r.y = (a - b + m) % m; r.bw = (a < b); end
      4:  begin v = a + 1;       r.y = v % m; r.c = (v >= m); end
      5:  begin r.y = (a + m - 1) % m; r.bw = (a == 0); end
      6:  r.y = a & b;
      7:  r.y = m - 1 - a;
      8:  begin r.y = (a * 2) % m + a / (m / 2); r.c = (a >= m / 2); end
      9:  begin r.y = a / 2 + (a % 2) * (m / 2); r.c = (a % 2 == 1); end
      10: r.y = a | b;
      11: r.y = a ^ b;
      12: begin v = a * b; r.y = v % m; r.hi = v / m; r.c = (r.hi != 0); end
      default: r.inv = 1;
    endcase
    r.z = !r.inv && (r.y == 0) && (r.hi == 0);
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'((r.y >> i) & 1) + int'((r.hi >> i) & 1);
    r.p = ones[0];
    return r;
  endfunction

  function automatic logic [20:0] exp8(int op, int a, int b, int cin);
    res_t r = model(8, op, a, b, cin);
    return {r.hi[7:0], r.y[7:0], r.c, r.bw, r.z, r.p, r.inv};
  endfunction

  function automatic logic [36:0] exp16(int op, int a, int b, int cin);
    res_t r = model(16, op, a, b, cin);
    return {r.hi[15:0], r.y[15:0], r.c, r.bw, r.z, r.p, r.inv};
  endfunction

  logic [20:0] got8;
  logic [36:0] got16;
  assign got8  = {if8.y_hi, if8.y, if8.carry_out, if8.borrow, if8.zero, if8.parity, if8.invalid_op};
  assign got16 = {if16.y_hi, if16.y, if16.carry_out, if16.borrow, if16.zero, if16.parity, if16.invalid_op};

  // Issues one op from IDLE, leaves the result pending (out_ready low); lat counts cycles to out_valid.
  task automatic send8(input int op, input int a, input int b, input int cin, output int lat);
    if8.op_code = 4'(op); if8.a = 8'(a); if8.b = 8'(b); if8.carry_in = 1'(cin);
    if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 1;
    while (!if8.out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic send16(input int op, input int a, input int b, input int cin, output int lat);
    if16.op_code = 4'(op); if16.a = 16'(a); if16.b = 16'(b); if16.carry_in = 1'(cin);
    if16.in_valid = 1'b1; if16.out_ready = 1'b0;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    lat = 1;
    while (!if16.out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic pop8();
    if8.out_ready = 1'b1; @(posedge clk); #1; if8.out_ready = 1'b0;
  endtask

  task automatic pop16();
    if16.out_ready = 1'b1; @(posedge clk); #1; if16.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if8.in_valid = 0; if8.out_ready = 0; if8.a = 0; if8.b = 0; if8.carry_in = 0; if8.op_code = 0;
    if16.in_valid = 0; if16.out_ready = 0; if16.a = 0; if16.b = 0; if16.carry_in = 0; if16.op_code = 0;
    #23;
    tests++;
    if ({got8, if8.out_valid, if8.busy} !== 23'd0) begin
      fails++; $display("FAIL reset8 got=%h exp=0", {got8, if8.out_valid, if8.busy});
    end
    tests++;
    if ({got16, if16.out_valid, if16.busy} !== 39'd0) begin
      fails++; $display("FAIL reset16 got=%h exp=0", {got16, if16.out_valid, if16.busy});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({if8.in_ready, if16.in_ready} !== 2'b11) begin
      fails++; $display("FAIL reset_in_ready got=%b exp=11", {if8.in_ready, if16.in_ready});
    end
  endtask

  task automatic test_directed();
    int lat;
    int ops[4]  = '{1, 3, 5, 2};
    int as[4]   = '{200, 100, 0, 255};
    int bs[4]   = '{100, 200, 0, 0};
    int cins[4] = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      send8(ops[i], as[i], bs[i], cins[i], lat);
      tests++;
      if (got8 !== exp8(ops[i], as[i], bs[i], cins[i]) || lat != 1) begin
        fails++;
        $display("FAIL directed op=%0d got=%h lat=%0d exp=%h lat=1", ops[i], got8, lat,
                 exp8(ops[i], as[i], bs[i], cins[i]));
      end
      pop8();
    end
    send8(14, 77, 33, 1, lat);
    tests++;
    if (if8.invalid_op !== 1'b1 || if8.y !== 8'd0 || if8.zero !== 1'b0 || lat != 1) begin
      fails++;
      $display("FAIL invalid_op inv=%b y=%h zero=%b lat=%0d exp inv=1 y=0 zero=0 lat=1",
               if8.invalid_op, if8.y, if8.zero, lat);
    end
    pop8();
  endtask

  task automatic test_mul8();
    int cycles = 1;
    int busy_cnt = 0;
    int rdy_hi = 0;
    if8.op_code = 4'd12; if8.a = 8'd200; if8.b = 8'd200; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    while (!if8.out_valid && cycles < 60) begin
      if (if8.busy) busy_cnt++;
      if (if8.in_ready) rdy_hi++;
      @(posedge clk); #1;
      cycles++;
    end
    tests++;
    if (cycles != 9 || busy_cnt != 8 || rdy_hi != 0 || if8.busy !== 1'b0) begin
      fails++;
      $display("FAIL mul8_timing lat=%0d busy=%0d rdy=%0d exp lat=9 busy=8 rdy=0", cycles, busy_cnt, rdy_hi);
    end
    tests++;
    if (got8 !== exp8(12, 200, 200, 0) || if8.y_hi !== 8'd156 || if8.y !== 8'd64) begin
      fails++; $display("FAIL mul8_value got=%h exp=%h", got8, exp8(12, 200, 200, 0));
    end
    pop8();
  endtask

  task automatic test_random8();
    int lat;
    int op, a, b, cin;
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 15)); a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255)); cin = int'($urandom_range(0, 1));
      if (i % 16 == 0) a = (i % 32 == 0) ? 0 : 255;
      send8(op, a, b, cin, lat);
      tests++;
      if (got8 !== exp8(op, a, b, cin) || lat != ((op == 12) ? 9 : 1)) begin
        fails++;
        $display("FAIL random8 op=%0d a=%0d b=%0d cin=%0d got=%h lat=%0d exp=%h", op, a, b, cin, got8,
                 lat, exp8(op, a, b, cin));
      end
      pop8();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [20:0] first;
    send8(1, 10, 20, 0, lat);
    first = got8;
    tests++;
    if (first !== exp8(1, 10, 20, 0)) begin
      fails++; $display("FAIL bp_first got=%h exp=%h", first, exp8(1, 10, 20, 0));
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (got8 !== first || if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d got=%h v=%b rdy=%b exp=%h v=1 rdy=0", i, got8, if8.out_valid,
                 if8.in_ready, first);
      end
    end
    if8.out_ready = 1'b1; if8.in_valid = 1'b1; if8.op_code = 4'd1; if8.a = 8'd7; if8.b = 8'd9;
    #1;
    tests++;
    if (if8.in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_ready got=%b exp=1", if8.in_ready);
    end
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if8.out_ready = 1'b0;
    tests++;
    if (if8.out_valid !== 1'b1 || got8 !== exp8(1, 7, 9, 0)) begin
      fails++; $display("FAIL bp_next v=%b got=%h exp v=1 %h", if8.out_valid, got8, exp8(1, 7, 9, 0));
    end
    pop8();
  endtask

  task automatic test_back_to_back();
    int op, a, b, cin;
    if8.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do op = int'($urandom_range(0, 15)); while (op == 12);
      a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255)); cin = int'($urandom_range(0, 1));
      if8.op_code = 4'(op); if8.a = 8'(a); if8.b = 8'(b); if8.carry_in = 1'(cin); if8.in_valid = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b1 || got8 !== exp8(op, a, b, cin)) begin
        fails++;
        $display("FAIL b2b i=%0d op=%0d v=%b rdy=%b got=%h exp=%h", i, op, if8.out_valid, if8.in_ready,
                 got8, exp8(op, a, b, cin));
      end
    end
    if8.in_valid = 1'b0;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    tests++;
    if (if8.out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain v=%b exp=0", if8.out_valid);
    end
  endtask

  task automatic test_mul_reset();
    int stale = 0;
    if8.op_code = 4'd12; if8.a = 8'd200; if8.b = 8'd200; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (if8.busy !== 1'b1) begin
      fails++; $display("FAIL mulrst_pre busy=%b exp=1", if8.busy);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (if8.out_valid !== 1'b0 || if8.busy !== 1'b0 || got8 !== 21'd0) begin
      fails++; $display("FAIL mulrst_async v=%b busy=%b got=%h exp 0 0 0", if8.out_valid, if8.busy, got8);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (if8.out_valid || if8.busy) stale++;
    end
    if8.out_ready = 1'b0;
    tests++;
    if (stale != 0) begin
      fails++; $display("FAIL mulrst_stale cycles=%0d exp=0", stale);
    end
  endtask

  task automatic test_bus16();
    int lat;
    int op, a, b, cin;
    send16(8, 16'h8001, 0, 0, lat);
    tests++;
    if (got16 !== exp16(8, 16'h8001, 0, 0) || if16.y !== 16'h0003 || if16.carry_out !== 1'b1) begin
      fails++; $display("FAIL rol16 got=%h exp=%h", got16, exp16(8, 16'h8001, 0, 0));
    end
    pop16();
    send16(12, 16'hFFFF, 16'hFFFF, 0, lat);
    tests++;
    if (got16 !== exp16(12, 16'hFFFF, 16'hFFFF, 0) || if16.y_hi !== 16'hFFFE || if16.y !== 16'h0001
        || lat != 17) begin
      fails++;
      $display("FAIL mul16 got=%h lat=%0d exp=%h lat=17", got16, lat, exp16(12, 16'hFFFF, 16'hFFFF, 0));
    end
    pop16();
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 15)); a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535)); cin = int'($urandom_range(0, 1));
      send16(op, a, b, cin, lat);
      tests++;
      if (got16 !== exp16(op, a, b, cin) || lat != ((op == 12) ? 17 : 1)) begin
        fails++;
        $display("FAIL random16 op=%0d a=%0d b=%0d got=%h lat=%0d exp=%h", op, a, b, got16, lat,
                 exp16(op, a, b, cin));
      end
      pop16();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_mul8();
    test_random8();
    test_backpressure();
    test_back_to_back();
    test_mul_reset();
    test_bus16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
